data_bus_if: RTL and testbench

- Data-side bus master that sits directly downstream of the memory-access stage.
- Takes that stage's single-cycle RAM request (ce, we, addr, sel, data) and runs it as a Wishbone B3 classic cycle of arbitrary latency.
- Holds the pipeline via a stall request until the acknowledge arrives.
- Returns read data to the memory-access stage on `mem_data_i`, and keeps it stable while the pipeline stays stalled.

---
 rtl/data_bus_if_pkg.sv | 14 +
 rtl/data_bus_if.sv | 120 ++++++++++++
 tb/tb_data_bus_if.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_if_pkg.sv
// Shared constants and state encoding for the data-side Wishbone bus master.
package data_bus_if_pkg;

    localparam logic        ChipEnable  = 1'b1;
    localparam logic        WriteEnable = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE           = 2'b00,
        BUSY           = 2'b01,
        WAIT_FOR_STALL = 2'b11
    } bus_state_t;

endpackage

// File: rtl/data_bus_if.sv
// Wishbone B3 classic master behind the memory-access stage; stalls the pipeline
// until ACK and holds read data while the pipeline remains stalled.
//
// state          | meaning
// ---------------+--------------------------------------------------------------
// IDLE           | no bus cycle; a valid, unflushed request starts one next edge
// BUSY           | STB/CYC asserted, waiting for ACK (or flush)
// WAIT_FOR_STALL | access done, pipeline still stalled; present captured read data
module data_bus_if
    import data_bus_if_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int STALL_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic              flush_i,
    input  logic              cpu_ce_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [3:0]        cpu_sel_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              stallreq_o,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              wb_ack_i,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              wb_we_o,
    output logic [3:0]        wb_sel_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o
);

    bus_state_t        state;
    logic [DATA_W-1:0] rd_buf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rd_buf    <= ZeroWord;
            wb_addr_o <= '0;
            wb_data_o <= ZeroWord;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= 4'b0000;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_ce_i == ChipEnable && !flush_i) begin
                        wb_addr_o <= cpu_addr_i;
                        wb_data_o <= cpu_data_i;
                        wb_we_o   <= cpu_we_i;
                        wb_sel_o  <= cpu_sel_i;
                        wb_stb_o  <= 1'b1;
                        wb_cyc_o  <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // Flush wins over a simultaneous ACK: the data is discarded.
                    if (flush_i || wb_ack_i) begin
                        wb_addr_o <= '0;
                        wb_data_o <= ZeroWord;
                        wb_we_o   <= 1'b0;
                        wb_sel_o  <= 4'b0000;
                        wb_stb_o  <= 1'b0;
                        wb_cyc_o  <= 1'b0;
                        if (flush_i) begin
                            state <= IDLE;
                        end else begin
                            if (wb_we_o != WriteEnable) begin
                                rd_buf <= wb_data_i;
                            end
                            state <= (stall_i != '0) ? WAIT_FOR_STALL : IDLE;
                        end
                    end
                end
                WAIT_FOR_STALL: begin
                    if (stall_i == '0 || flush_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = ZeroWord;
        if (rst) begin
            case (state)
                IDLE: begin
                    stallreq_o = (cpu_ce_i == ChipEnable) && !flush_i;
                end
                BUSY: begin
                    if (flush_i) begin
                        stallreq_o = 1'b0;
                    end else if (wb_ack_i) begin
                        stallreq_o = 1'b0;
                        cpu_data_o = (wb_we_o == WriteEnable) ? ZeroWord : wb_data_i;
                    end else begin
                        stallreq_o = 1'b1;
                    end
                end
                WAIT_FOR_STALL: begin
                    cpu_data_o = rd_buf;
                end
                default: begin
                    stallreq_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_if.sv
// Self-checking bench for data_bus_if: directed scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a transaction-level model.
module tb_data_bus_if;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall_i = '0;
    logic        flush_i = 1'b0;
    logic        cpu_ce_i = 1'b0;
    logic        cpu_we_i = 1'b0;
    logic [31:0] cpu_addr_i = '0;
    logic [3:0]  cpu_sel_i = '0;
    logic [31:0] cpu_data_i = '0;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic [31:0] wb_data_i = '0;
    logic        wb_ack_i = 1'b0;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_bus_if #(.ADDR_W(32), .DATA_W(32), .STALL_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .wb_data_i  (wb_data_i),
        .wb_ack_i   (wb_ack_i),
        .wb_addr_o  (wb_addr_o),
        .wb_data_o  (wb_data_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: an outstanding access, a "holding read data" flag,
    // and the last value read back from the bus.
    bit          m_busy;
    bit          m_hold;
    logic [31:0] m_addr, m_data, m_rd;
    bit          m_we;
    logic [3:0]  m_sel;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 0; m_hold <= 0; m_rd <= '0;
            m_addr <= '0; m_data <= '0; m_we <= 0; m_sel <= '0;
        end else if (m_hold) begin
            if (stall_i == 0 || flush_i) m_hold <= 0;
        end else if (m_busy) begin
            if (flush_i) begin
                m_busy <= 0;
            end else if (wb_ack_i) begin
                m_busy <= 0;
                if (!m_we) m_rd <= wb_data_i;
                m_hold <= (stall_i != 0);
            end
        end else if (cpu_ce_i && !flush_i) begin
            m_busy <= 1;
            m_addr <= cpu_addr_i; m_data <= cpu_data_i;
            m_we   <= cpu_we_i;   m_sel  <= cpu_sel_i;
        end
    end

    always @(negedge clk) begin
        logic        e_stall;
        logic [31:0] e_data;
        e_stall = 0;
        e_data  = '0;
        if (!rst) begin
            e_stall = 0;
        end else if (m_hold) begin
            e_data = m_rd;
        end else if (m_busy) begin
            if (!flush_i && wb_ack_i) e_data = m_we ? 32'h0 : wb_data_i;
            else if (!flush_i)        e_stall = 1;
        end else begin
            e_stall = cpu_ce_i && !flush_i;
        end
        chk("model stallreq", {31'b0, stallreq_o}, {31'b0, e_stall});
        chk("model cpu_data", cpu_data_o, e_data);
        chk("model wb_cyc",   {31'b0, wb_cyc_o}, {31'b0, m_busy});
        chk("model wb_stb",   {31'b0, wb_stb_o}, {31'b0, m_busy});
        chk("model wb_addr",  wb_addr_o, m_busy ? m_addr : 32'h0);
        chk("model wb_data",  wb_data_o, m_busy ? m_data : 32'h0);
        chk("model wb_we",    {31'b0, wb_we_o}, {31'b0, m_busy && m_we});
        chk("model wb_sel",   {28'b0, wb_sel_o}, {28'b0, m_busy ? m_sel : 4'h0});
    end

    task automatic set_in(input bit ce, input bit we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] data,
                          input logic [5:0] stall, input bit flush, input bit ack,
                          input logic [31:0] wbd);
        cpu_ce_i = ce; cpu_we_i = we; cpu_addr_i = addr; cpu_sel_i = sel;
        cpu_data_i = data; stall_i = stall; flush_i = flush; wb_ack_i = ack;
        wb_data_i = wbd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        set_in(0, 0, 32'h0, 4'h0, 32'h0, 6'h0, 0, 0, 32'h0);
    endtask

    initial begin
        idle_in();
        #3;
        chk("reset stallreq", {31'b0, stallreq_o}, 32'h0);
        chk("reset cpu_data", cpu_data_o, 32'h0);
        chk("reset cyc", {31'b0, wb_cyc_o}, 32'h0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Read, zero wait states
        set_in(1, 0, 32'h0000_0100, 4'hF, 32'h0, 6'h0, 0, 0, 32'h0);
        #3; chk("rd0 req stallreq", {31'b0, stallreq_o}, 32'h1);
        tick();
        set_in(0, 0, 32'h0, 4'h0, 32'h0, 6'h0, 0, 1, 32'hDEAD_BEEF);
        #3; chk("rd0 stb", {31'b0, wb_stb_o}, 32'h1);
        chk("rd0 addr", wb_addr_o, 32'h0000_0100);
        chk("rd0 ack stallreq", {31'b0, stallreq_o}, 32'h0);
        chk("rd0 data", cpu_data_o, 32'hDEAD_BEEF);
        tick();
        idle_in();
        #3; chk("rd0 after cyc", {31'b0, wb_cyc_o}, 32'h0);
        chk("rd0 after data", cpu_data_o, 32'h0);
        tick();

        // Write, three wait states
        set_in(1, 1, 32'h0000_0204, 4'h3, 32'h1234_5678, 6'h0, 0, 0, 32'h0);
        #3; chk("wr3 req stallreq", {31'b0, stallreq_o}, 32'h1);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 32'h0, 4'h0, 32'h0, 6'h0, 0, 0, 32'h0);
            #3; chk("wr3 we", {31'b0, wb_we_o}, 32'h1);
            chk("wr3 sel", {28'b0, wb_sel_o}, 32'h3);
            chk("wr3 dat", wb_data_o, 32'h1234_5678);
            chk("wr3 stallreq", {31'b0, stallreq_o}, 32'h1);
            tick();
        end
        set_in(0, 0, 32'h0, 4'h0, 32'h0, 6'h0, 0, 1, 32'hFFFF_FFFF);
        #3; chk("wr3 ack stallreq", {31'b0, stallreq_o}, 32'h0);
        chk("wr3 ack data", cpu_data_o, 32'h0);
        tick();

        // Read with stall held after ACK; a request in WAIT_FOR_STALL is ignored
        idle_in(); tick();
        set_in(1, 0, 32'h0000_0300, 4'hF, 32'h0, 6'h0, 0, 0, 32'h0);
        tick();
        set_in(0, 0, 32'h0, 4'h0, 32'h0, 6'h03, 0, 1, 32'hA5A5_0001);
        #3; chk("rdst ack data", cpu_data_o, 32'hA5A5_0001);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 32'h0000_0400, 4'hF, 32'h0, 6'h03, 0, 0, 32'h1111_2222);
            #3; chk("rdst hold data", cpu_data_o, 32'hA5A5_0001);
            chk("rdst hold stallreq", {31'b0, stallreq_o}, 32'h0);
            chk("rdst no new cyc", {31'b0, wb_cyc_o}, 32'h0);
            tick();
        end
        idle_in();
        #3; chk("rdst release data", cpu_data_o, 32'hA5A5_0001);
        tick();
        #3; chk("rdst idle data", cpu_data_o, 32'h0);
        tick();

        // Flush in BUSY; read data discarded
        set_in(1, 0, 32'h0000_0500, 4'hF, 32'h0, 6'h0, 0, 0, 32'h0);
        tick();
        set_in(0, 0, 32'h0, 4'h0, 32'h0, 6'h0, 0, 0, 32'h0);
        #3; chk("fl busy stallreq", {31'b0, stallreq_o}, 32'h1);
        tick();
        set_in(0, 0, 32'h0, 4'h0, 32'h0, 6'h0, 1, 1, 32'h0BAD_F00D);
        #3; chk("fl stallreq", {31'b0, stallreq_o}, 32'h0);
        chk("fl data", cpu_data_o, 32'h0);
        tick();
        idle_in();
        #3; chk("fl cyc", {31'b0, wb_cyc_o}, 32'h0);
        chk("fl stb", {31'b0, wb_stb_o}, 32'h0);
        tick();
        // A write held by stall exposes rd_buf: still the earlier read value
        set_in(1, 1, 32'h0000_0600, 4'hF, 32'h5555_AAAA, 6'h0, 0, 0, 32'h0);
        tick();
        set_in(0, 0, 32'h0, 4'h0, 32'h0, 6'h01, 0, 1, 32'h7777_7777);
        tick();
        set_in(0, 0, 32'h0, 4'h0, 32'h0, 6'h01, 0, 0, 32'h0);
        #3; chk("fl rd_buf kept", cpu_data_o, 32'hA5A5_0001);
        tick();
        idle_in(); tick(); tick();

        // Async reset in BUSY
        set_in(1, 1, 32'h0000_0700, 4'hC, 32'hFACE_0001, 6'h0, 0, 0, 32'h0);
        tick();
        idle_in();
        #1; chk("ar cyc before", {31'b0, wb_cyc_o}, 32'h1);
        rst = 1'b0;
        #1; chk("ar cyc", {31'b0, wb_cyc_o}, 32'h0);
        chk("ar stb", {31'b0, wb_stb_o}, 32'h0);
        chk("ar we", {31'b0, wb_we_o}, 32'h0);
        chk("ar sel", {28'b0, wb_sel_o}, 32'h0);
        chk("ar addr", wb_addr_o, 32'h0);
        chk("ar dat", wb_data_o, 32'h0);
        tick();
        rst = 1'b1;
        tick(); tick();
        #3; chk("ar idle cyc", {31'b0, wb_cyc_o}, 32'h0);
        chk("ar idle stallreq", {31'b0, stallreq_o}, 32'h0);
        tick();

        // Back-to-back read then write, one wait state each
        set_in(1, 0, 32'h0000_0010, 4'hF, 32'h0, 6'h0, 0, 0, 32'h0);
        tick();
        set_in(0, 0, 32'h0, 4'h0, 32'h0, 6'h0, 0, 0, 32'h0);
        tick();
        set_in(0, 0, 32'h0, 4'h0, 32'h0, 6'h0, 0, 1, 32'hCAFE_0010);
        #3; chk("b2b rd data", cpu_data_o, 32'hCAFE_0010);
        tick();
        set_in(1, 1, 32'h0000_0014, 4'hF, 32'h0BB0_0014, 6'h0, 0, 0, 32'h0);
        #3; chk("b2b gap cyc", {31'b0, wb_cyc_o}, 32'h0);
        tick();
        set_in(0, 0, 32'h0, 4'h0, 32'h0, 6'h0, 0, 0, 32'h0);
        #3; chk("b2b wr addr", wb_addr_o, 32'h0000_0014);
        chk("b2b wr we", {31'b0, wb_we_o}, 32'h1);
        tick();
        set_in(0, 0, 32'h0, 4'h0, 32'h0, 6'h0, 0, 1, 32'h0);
        tick();
        idle_in(); tick();

        // Randomized traffic; slave ACKs only while STB is up
        for (int i = 0; i < 2000; i++) begin
            logic [5:0] st;
            st = ($urandom_range(0, 9) < 3) ? 6'($urandom_range(1, 63)) : 6'h0;
            set_in(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), $urandom,
                   4'($urandom), $urandom, st, ($urandom_range(0, 19) == 0),
                   wb_stb_o && ($urandom_range(0, 9) < 4), $urandom);
            tick();
        end
        idle_in();
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
